fifo_rr_write_arbiter: RTL and testbench

//  Shares the write port of one generic_sync_fifo between NUM_REQ producers.

---
 rtl/fifo_rr_write_arbiter_if.sv | 28 ++
 rtl/fifo_rr_write_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_rr_write_arbiter_if.sv
// Producer-side beat handshake plus FIFO write port, bundled for the
// round-robin FIFO write arbiter.
interface fifo_rr_write_arbiter_if #(
  parameter type DTYPE    = logic [7:0],
  parameter int  NUM_REQ  = 4,
  parameter int  ID_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  DTYPE [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic               fifo_wen;
  DTYPE               fifo_wdata;
  logic               fifo_full;
  logic               fifo_afull;
  logic [ID_WIDTH-1:0] grant_id;
  logic               busy;

  modport slave (
    input  req_valid, req_last, req_data, fifo_full, fifo_afull,
    output req_ready, fifo_wen, fifo_wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_last, req_data, fifo_full, fifo_afull,
    input  req_ready, fifo_wen, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with burst lock capped at MAX_BURST beats per grant.
module fifo_rr_write_arbiter #(
  parameter type DTYPE     = logic [7:0],
  parameter int  NUM_REQ   = 4,
  parameter int  MAX_BURST = 4,
  parameter int  ID_WIDTH  = $clog2(NUM_REQ),
  parameter int  CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  fifo_rr_write_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_q, rr_d;
  logic [ID_WIDTH-1:0]  gid_q, gid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [ID_WIDTH-1:0]  sel;
  logic [ID_WIDTH:0]    idx;
  logic                 found;
  logic                 grant;
  logic                 beat;
  logic                 single;
  DTYPE                 wdata;

  function automatic logic [ID_WIDTH-1:0] nxt(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Selection and beat accept; ready never looks at ready, only valid/last/full.
  always_comb begin
    sel   = gid_q;
    idx   = '0;
    found = 1'b0;
    grant = 1'b0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_q} + (ID_WIDTH+1)'(k);
        if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
        if (!found && bus.req_valid[idx[ID_WIDTH-1:0]]) begin
          found = 1'b1;
          sel   = idx[ID_WIDTH-1:0];
        end
      end
      grant = found && !bus.fifo_full &&
              (bus.req_last[sel] || MAX_BURST == 1 || !bus.fifo_afull);
    end else begin
      grant = !bus.fifo_full;
    end
    if (!rst_n || clear) grant = 1'b0;
    beat   = grant && bus.req_valid[sel];
    single = bus.req_last[sel] || MAX_BURST == 1;
    wdata  = bus.req_data[sel];
  end

  assign bus.req_ready  = grant ? (NUM_REQ'(1) << sel) : '0;
  assign bus.fifo_wen   = beat;
  assign bus.fifo_wdata = wdata;
  assign bus.grant_id   = gid_q;
  assign bus.busy       = busy_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (clear) begin
      state_d = IDLE;
      rr_d    = '0;
      gid_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (beat) begin
      case (state_q)
        IDLE: begin
          gid_d = sel;
          if (single) begin
            rr_d = nxt(sel);
          end else begin
            state_d = BURST;
            cnt_d   = CNT_WIDTH'(1);
            busy_d  = 1'b1;
          end
        end
        BURST: begin
          if (bus.req_last[gid_q] || (cnt_q + 1'b1) == CNT_WIDTH'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = nxt(gid_q);
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter: reset, RR fairness, bursts,
// burst cap, backpressure, afull gating and clear.
module tb_fifo_rr_write_arbiter;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fifo_rr_write_arbiter_if #(.DTYPE(logic [7:0]), .NUM_REQ(NUM_REQ)) bus ();

  fifo_rr_write_arbiter #(.DTYPE(logic [7:0]), .NUM_REQ(NUM_REQ), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] v, input logic [3:0] l,
                     input logic full, input logic afull);
    bus.req_valid  = v;
    bus.req_last   = l;
    bus.fifo_full  = full;
    bus.fifo_afull = afull;
    #1;
  endtask

  task automatic beat_chk(input string tag, input logic [3:0] rdy, input logic [7:0] d);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, "_wen"},   32'(bus.fifo_wen), 32'(rdy != 4'b0));
    if (rdy != 4'b0) chk({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(d));
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i] = 8'hA0 + 8'(i);

    // Reset with everyone requesting
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    beat_chk("rst", 4'b0000, 8'h00);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gid",  32'(bus.grant_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin: 0,1,2,3,0
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      beat_chk($sformatf("rr%0d", k), 4'b0001 << (k % 4), 8'hA0 + 8'(k % 4));
      tick();
      chk($sformatf("rr%0d_gid", k), 32'(bus.grant_id), k % 4);
    end
    // rr_ptr = 1: req1 bursts 3 beats while req0/req2 wait
    drv(4'b0111, 4'b0101, 1'b0, 1'b0);
    beat_chk("b3_1", 4'b0010, 8'hA1);
    tick();
    chk("b3_busy1", 32'(bus.busy), 1);
    chk("b3_gid",   32'(bus.grant_id), 1);
    beat_chk("b3_2", 4'b0010, 8'hA1);
    tick();
    drv(4'b0111, 4'b0111, 1'b0, 1'b0);
    beat_chk("b3_3", 4'b0010, 8'hA1);
    tick();
    chk("b3_busy3", 32'(bus.busy), 0);
    beat_chk("b3_next", 4'b0100, 8'hA2);
    tick();
    chk("b3_next_gid", 32'(bus.grant_id), 2);

    // rr_ptr = 3: req0 never asserts last, capped at 4 beats
    drv(4'b0011, 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat_chk($sformatf("cap%0d", k), 4'b0001, 8'hA0);
      tick();
      chk($sformatf("cap%0d_busy", k), 32'(bus.busy), (k < 3) ? 1 : 0);
    end
    beat_chk("cap_next", 4'b0010, 8'hA1);
    tick();
    chk("cap_next_gid", 32'(bus.grant_id), 1);

    // rr_ptr = 2: req2 burst with 2 full cycles after beat 1
    drv(4'b0100, 4'b0000, 1'b0, 1'b0);
    beat_chk("bp1", 4'b0100, 8'hA2);
    tick();
    drv(4'b0100, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      beat_chk($sformatf("bp_full%0d", k), 4'b0000, 8'h00);
      chk($sformatf("bp_full%0d_busy", k), 32'(bus.busy), 1);
      tick();
    end
    drv(4'b0100, 4'b0000, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      beat_chk($sformatf("bp%0d", k), 4'b0100, 8'hA2);
      tick();
      chk($sformatf("bp%0d_busy", k), 32'(bus.busy), (k < 4) ? 1 : 0);
    end

    // rr_ptr = 3: afull blocks req0 multi-beat start, not req1 single beat
    drv(4'b0011, 4'b0010, 1'b0, 1'b1);
    beat_chk("af_block", 4'b0000, 8'h00);
    tick();
    chk("af_block_busy", 32'(bus.busy), 0);
    drv(4'b0010, 4'b0010, 1'b0, 1'b1);
    beat_chk("af_single", 4'b0010, 8'hA1);
    tick();
    chk("af_single_gid",  32'(bus.grant_id), 1);
    chk("af_single_busy", 32'(bus.busy), 0);

    // rr_ptr = 2: clear during beat 2 of req2 burst
    drv(4'b0100, 4'b0000, 1'b0, 1'b0);
    beat_chk("clr_b1", 4'b0100, 8'hA2);
    tick();
    clear = 1'b1;
    #1;
    beat_chk("clr_b2", 4'b0000, 8'h00);
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_gid",  32'(bus.grant_id), 0);
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    beat_chk("clr_rr0", 4'b0001, 8'hA0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end expected finish");
    $fatal(1, "timeout");
  end
endmodule
